// File: rtl/multdiv_hazard_ctrl_if.sv
// Decode-side issue/hazard signals and mult/div unit handshake shared with the controller.
interface multdiv_hazard_ctrl_if;
  logic       issue_valid;
  logic       issue_is_div;
  logic [4:0] issue_rd;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic [4:0] dec_rd;
  logic       dec_writes;
  logic       md_ready;
  logic       md_exception;
  logic       md_ctrl_mult;
  logic       md_ctrl_div;
  logic       stall;
  logic       busy;
  logic       wb_steal;
  logic [4:0] wb_rd;
  logic       wb_exc;
  logic       timeout_err;

  modport master (
    output issue_valid, issue_is_div, issue_rd, src_a, src_b, dec_rd, dec_writes,
    output md_ready, md_exception,
    input  md_ctrl_mult, md_ctrl_div, stall, busy, wb_steal, wb_rd, wb_exc, timeout_err
  );

  modport slave (
    input  issue_valid, issue_is_div, issue_rd, src_a, src_b, dec_rd, dec_writes,
    input  md_ready, md_exception,
    output md_ctrl_mult, md_ctrl_div, stall, busy, wb_steal, wb_rd, wb_exc, timeout_err
  );
endinterface

// File: rtl/multdiv_hazard_ctrl.sv
// Single-slot mult/div scheduler: start pulse one cycle after accept, RAW/WAW stall on the pending rd,
// one-cycle write-port steal after md_ready; decode is stalled while busy on hazard or a second issue.
module multdiv_hazard_ctrl #(
  parameter int MAX_CYCLES = 40
) (
  input logic                clock,
  input logic                reset,
  multdiv_hazard_ctrl_if.slave md
);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t          state, state_nx;
  logic [4:0]      pend_rd, pend_rd_nx;
  logic            pend_div, pend_div_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            exc_q, exc_nx;
  logic            first_q, first_nx;
  logic            timeout_q, timeout_nx;

  logic match_a, match_b, match_d, hazard;

  // $r0 is never a real destination, so it can't create a dependency.
  assign match_a = (md.src_a  == pend_rd) && (pend_rd != 5'd0);
  assign match_b = (md.src_b  == pend_rd) && (pend_rd != 5'd0);
  assign match_d = (md.dec_rd == pend_rd) && (pend_rd != 5'd0);
  assign hazard  = match_a || match_b || (md.dec_writes && match_d) || md.issue_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      pend_rd   <= 5'd0;
      pend_div  <= 1'b0;
      cnt       <= '0;
      exc_q     <= 1'b0;
      first_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      pend_rd   <= pend_rd_nx;
      pend_div  <= pend_div_nx;
      cnt       <= cnt_nx;
      exc_q     <= exc_nx;
      first_q   <= first_nx;
      timeout_q <= timeout_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pend_rd_nx  = pend_rd;
    pend_div_nx = pend_div;
    cnt_nx      = cnt;
    exc_nx      = exc_q;
    first_nx    = first_q;
    timeout_nx  = timeout_q;

    case (state)
      IDLE: begin
        if (md.issue_valid) begin
          pend_rd_nx  = md.issue_rd;
          pend_div_nx = md.issue_is_div;
          cnt_nx      = '0;
          first_nx    = 1'b1;
          state_nx    = BUSY;
        end
      end
      BUSY: begin
        // The start cycle counts toward residency but never samples md_ready.
        if (first_q) begin
          first_nx = 1'b0;
          cnt_nx   = cnt + CW'(1);
        end else if (md.md_ready) begin
          exc_nx   = md.md_exception;
          state_nx = WB;
        end else if (cnt == CW'(MAX_CYCLES - 1)) begin
          timeout_nx = 1'b1;
          pend_rd_nx = 5'd0;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WB: begin
        pend_rd_nx = 5'd0;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign md.busy         = (state != IDLE);
  assign md.md_ctrl_mult = (state == BUSY) && first_q && !pend_div;
  assign md.md_ctrl_div  = (state == BUSY) && first_q && pend_div;
  assign md.stall        = ((state == BUSY) && hazard) || (state == WB);
  assign md.wb_steal     = (state == WB) && (pend_rd != 5'd0);
  assign md.wb_rd        = md.wb_steal ? pend_rd : 5'd0;
  assign md.wb_exc       = md.wb_steal ? exc_q : 1'b0;
  assign md.timeout_err  = timeout_q;
endmodule

// File: tb/tb_multdiv_hazard_ctrl.sv
// Scoreboarded bench: writebacks are queued at issue and matched whenever wb_steal fires.
module tb_multdiv_hazard_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multdiv_hazard_ctrl_if mif();
  multdiv_hazard_ctrl_if tif();

  multdiv_hazard_ctrl #(.MAX_CYCLES(40)) u_dut (.clock(clock), .reset(reset), .md(mif));
  multdiv_hazard_ctrl #(.MAX_CYCLES(8))  u_dut_to (.clock(clock), .reset(reset), .md(tif));

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [4:0] rd;
    logic       exc;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;

  logic [4:0] hz_a [5] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd3};
  logic [4:0] hz_b [5] = '{5'd0, 5'd5, 5'd0, 5'd0, 5'd0};
  logic [4:0] hz_d [5] = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0};
  logic       hz_w [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       hz_s [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    mif.issue_valid = 0; mif.issue_is_div = 0; mif.issue_rd = 0;
    mif.src_a = 0; mif.src_b = 0; mif.dec_rd = 0; mif.dec_writes = 0;
    mif.md_ready = 0; mif.md_exception = 0;
    tif.issue_valid = 0; tif.issue_is_div = 0; tif.issue_rd = 0;
    tif.src_a = 0; tif.src_b = 0; tif.dec_rd = 0; tif.dec_writes = 0;
    tif.md_ready = 0; tif.md_exception = 0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({mif.md_ctrl_mult, mif.md_ctrl_div, mif.stall, mif.busy,
                mif.wb_steal, mif.wb_rd, mif.wb_exc, mif.timeout_err});
  endfunction

  function automatic logic exp_stall(input logic [4:0] rd);
    return (rd != 0) && (mif.src_a == rd || mif.src_b == rd ||
                         (mif.dec_writes && mif.dec_rd == rd));
  endfunction

  // Any write-port steal must match the oldest outstanding expected writeback.
  always @(negedge clock) begin
    if (reset && mif.wb_steal === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("wb_unexpected", 32'(mif.wb_steal), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_wb_rd", 32'(mif.wb_rd), 32'(mon_e.rd));
        check_eq("sb_wb_exc", 32'(mif.wb_exc), 32'(mon_e.exc));
      end
    end
  end

  // Must be called in an IDLE cycle; leaves the DUT in IDLE.
  task automatic run_op(input logic [4:0] rd, input logic div, input logic exc,
                        input int lat, input string tag);
    mif.issue_valid = 1; mif.issue_is_div = div; mif.issue_rd = rd;
    settle();
    check_eq({tag, "_accept_stall"}, 32'(mif.stall), 32'(0));
    if (rd != 0) exp_q.push_back(wb_t'({rd, exc}));
    tick();
    mif.issue_valid = 0;
    settle();
    check_eq({tag, "_pulse"}, 32'({mif.md_ctrl_div, mif.md_ctrl_mult}), div ? 32'd2 : 32'd1);
    repeat (lat) begin
      tick();
      settle();
      check_eq({tag, "_busy_stall"}, 32'(mif.stall), 32'(exp_stall(rd)));
    end
    tick();
    mif.md_ready = 1; mif.md_exception = exc;
    tick();
    mif.md_ready = 0; mif.md_exception = 0;
    settle();
    check_eq({tag, "_wb_steal"}, 32'(mif.wb_steal), 32'(rd != 0));
    check_eq({tag, "_wb_rd"}, 32'(mif.wb_rd), 32'(rd));
    check_eq({tag, "_wb_exc"}, 32'(mif.wb_exc), 32'((rd != 0) && exc));
    tick();
    settle();
    check_eq({tag, "_idle_busy"}, 32'(mif.busy), 32'(0));
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    tick(); tick();
    settle();
    check_eq("reset_outs", all_outs(), 32'(0));
    reset = 1;
    tick();

    // Mult rd=5 with hazard probes during BUSY
    mif.issue_valid = 1; mif.issue_is_div = 0; mif.issue_rd = 5;
    settle();
    check_eq("mult_idle_stall", 32'(mif.stall), 32'(0));
    exp_q.push_back(wb_t'({5'd5, 1'b0}));
    tick();
    mif.issue_valid = 0;
    settle();
    check_eq("mult_pulse", 32'({mif.md_ctrl_div, mif.md_ctrl_mult, mif.busy}), 32'b011);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i <= 5) begin
        mif.src_a = hz_a[i-1]; mif.src_b = hz_b[i-1];
        mif.dec_rd = hz_d[i-1]; mif.dec_writes = hz_w[i-1];
      end else begin
        mif.src_a = 0; mif.src_b = 0; mif.dec_rd = 0; mif.dec_writes = 0;
      end
      settle();
      if (i <= 5) check_eq($sformatf("hazard_%0d", i), 32'(mif.stall), 32'(hz_s[i-1]));
      if (i == 1) check_eq("mult_pulse_once", 32'(mif.md_ctrl_mult), 32'(0));
    end
    tick();
    mif.md_ready = 1; mif.src_a = 5;
    settle();
    check_eq("ready_cycle_stall", 32'(mif.stall), 32'(1));
    tick();
    mif.md_ready = 0;
    settle();
    check_eq("mult_wb", 32'({mif.wb_steal, mif.wb_rd, mif.wb_exc, mif.stall}), 32'({1'b1, 5'd5, 1'b0, 1'b1}));
    tick();
    settle();
    check_eq("mult_release", 32'({mif.busy, mif.stall}), 32'(0));
    mif.src_a = 0;

    // Writes to $r0 never stall and are discarded
    mif.dec_writes = 1;
    run_op(5'd0, 1'b0, 1'b0, 3, "r0");
    mif.dec_writes = 0;

    // Back-to-back div: second issue held until the first IDLE cycle
    mif.issue_valid = 1; mif.issue_is_div = 1; mif.issue_rd = 9;
    exp_q.push_back(wb_t'({5'd9, 1'b0}));
    tick();
    mif.issue_rd = 7;
    settle();
    check_eq("b2b_pulse_div", 32'({mif.md_ctrl_div, mif.stall}), 32'b11);
    repeat (3) begin
      tick();
      settle();
      check_eq("b2b_busy_stall", 32'(mif.stall), 32'(1));
    end
    tick();
    mif.md_ready = 1;
    tick();
    mif.md_ready = 0;
    settle();
    check_eq("b2b_wb", 32'({mif.wb_steal, mif.wb_rd, mif.stall}), 32'({1'b1, 5'd9, 1'b1}));
    tick();
    settle();
    check_eq("b2b_idle", 32'({mif.busy, mif.stall}), 32'(0));
    exp_q.push_back(wb_t'({5'd7, 1'b1}));
    tick();
    mif.issue_valid = 0;
    settle();
    check_eq("b2b_second_pulse", 32'({mif.md_ctrl_div, mif.md_ctrl_mult, mif.busy}), 32'b101);
    repeat (2) tick();
    tick();
    mif.md_ready = 1; mif.md_exception = 1;
    tick();
    mif.md_ready = 0; mif.md_exception = 0;
    settle();
    check_eq("div_exc_wb", 32'({mif.wb_steal, mif.wb_rd, mif.wb_exc}), 32'({1'b1, 5'd7, 1'b1}));
    tick();

    // Reset during the 4th BUSY cycle
    mif.issue_valid = 1; mif.issue_is_div = 0; mif.issue_rd = 12;
    exp_q.push_back(wb_t'({5'd12, 1'b0}));
    tick();
    mif.issue_valid = 0;
    tick(); tick(); tick();
    reset = 0;
    tick();
    reset = 1;
    exp_q.delete();
    settle();
    check_eq("midop_reset_outs", all_outs(), 32'(0));
    mif.md_ready = 1;
    tick();
    mif.md_ready = 0;
    settle();
    check_eq("late_ready_ignored", 32'({mif.wb_steal, mif.busy}), 32'(0));
    tick();
    run_op(5'd12, 1'b0, 1'b0, 5, "post_rst");

    // Timeout instance (MAX_CYCLES=8): ready never arrives
    tif.issue_valid = 1; tif.issue_rd = 4;
    tick();
    tif.issue_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      settle();
      check_eq($sformatf("to_busy_c%0d", c), 32'({tif.busy, tif.wb_steal, tif.timeout_err}), 32'b100);
      tick();
    end
    settle();
    check_eq("to_fired", 32'({tif.timeout_err, tif.busy, tif.wb_steal}), 32'b100);
    tick();
    settle();
    check_eq("to_sticky", 32'(tif.timeout_err), 32'(1));

    // Timeout instance: ready in BUSY cycle 8 wins over timeout
    reset = 0;
    tick();
    reset = 1;
    settle();
    check_eq("to_reset_clear", 32'(tif.timeout_err), 32'(0));
    tif.issue_valid = 1; tif.issue_rd = 4;
    tick();
    tif.issue_valid = 0;
    repeat (7) tick();
    tif.md_ready = 1;
    tick();
    tif.md_ready = 0;
    settle();
    check_eq("to_edge_wb", 32'({tif.wb_steal, tif.wb_rd, tif.timeout_err}), 32'({1'b1, 5'd4, 1'b0}));
    tick();
    settle();
    check_eq("to_edge_idle", 32'({tif.busy, tif.timeout_err}), 32'(0));

    tick();
    check_eq("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
